// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module  : ctrl_pkg
// Purpose : Shared types and constants for the exception controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0040;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/except_prio.sv
// ============================================================================
// Module  : except_prio
// Purpose : Combinational interrupt-pending check and exception priority encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module except_prio
  import ctrl_pkg::*;
(
  input  logic        i_en,
  input  logic        i_ie,
  input  logic        i_exl,
  input  logic [7:0]  i_im,
  input  logic [7:0]  i_ip,
  input  logic        i_timer_interrupt,
  input  logic        i_syscall,
  input  logic        i_inv_inst,
  input  logic        i_trap,
  input  logic        i_ovf,
  input  logic        i_eret,
  output logic        o_hit,
  output logic [31:0] o_code
);

  logic w_int_pending;

  // Timer interrupt is wired onto IP7 before masking.
  assign w_int_pending = i_ie & ~i_exl &
                         (|((i_ip | {i_timer_interrupt, 7'b0}) & i_im));

  always_comb begin
    o_hit  = 1'b0;
    o_code = EXC_NONE;
    if (i_en) begin
      o_hit = 1'b1;
      if (w_int_pending)   o_code = EXC_INT;
      else if (i_syscall)  o_code = EXC_SYSCALL;
      else if (i_inv_inst) o_code = EXC_INV;
      else if (i_trap)     o_code = EXC_TRAP;
      else if (i_ovf)      o_code = EXC_OVF;
      else if (i_eret)     o_code = EXC_ERET;
      else                 o_hit  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/except_ctrl.sv
// ============================================================================
// Module  : except_ctrl
// Purpose : Exception/interrupt sequencer: detect, flush/redirect, settle; stall mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

module except_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_req_id,
  input  logic        i_stall_req_ex,
  input  logic        i_mem_vld,
  input  logic        i_mem_syscall,
  input  logic        i_mem_inv_inst,
  input  logic        i_mem_trap,
  input  logic        i_mem_ovf,
  input  logic        i_mem_eret,
  input  logic [31:0] i_mem_inst_addr,
  input  logic        i_mem_delayslot,
  input  logic [31:0] i_cp0_status,
  input  logic [31:0] i_cp0_cause,
  input  logic [31:0] i_cp0_epc,
  input  logic        i_timer_interrupt,
  output logic [31:0] o_except_type,
  output logic [31:0] o_curr_inst_addr,
  output logic        o_delayslot_vld,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
  output logic [5:0]  o_stall,
  output logic [15:0] o_except_cnt
);

  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] except_cnt_q, except_cnt_d;
  logic        w_det_en;
  logic        w_hit;
  logic [31:0] w_code;
  logic [5:0]  w_stall_req;
  logic        w_unused;

  assign w_unused = ^{i_cp0_status[31:16], i_cp0_status[7:2],
                      i_cp0_cause[31:16], i_cp0_cause[7:0]};

  assign w_det_en = (state_q == ST_IDLE) && i_mem_vld;

  except_prio u_prio (
    .i_en              (w_det_en),
    .i_ie              (i_cp0_status[0]),
    .i_exl             (i_cp0_status[1]),
    .i_im              (i_cp0_status[15:8]),
    .i_ip              (i_cp0_cause[15:8]),
    .i_timer_interrupt (i_timer_interrupt),
    .i_syscall         (i_mem_syscall),
    .i_inv_inst        (i_mem_inv_inst),
    .i_trap            (i_mem_trap),
    .i_ovf             (i_mem_ovf),
    .i_eret            (i_mem_eret),
    .o_hit             (w_hit),
    .o_code            (w_code)
  );

  assign w_stall_req = i_stall_req_ex ? STALL_EX :
                       i_stall_req_id ? STALL_ID : STALL_NONE;

  always_comb begin
    state_d       = state_q;
    new_pc_d      = new_pc_q;
    except_cnt_d  = except_cnt_q;
    o_flush       = 1'b0;
    o_stall       = STALL_NONE;
    o_except_type = EXC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (w_hit) begin
          o_except_type = w_code;
          state_d       = ST_FLUSH;
          new_pc_d      = (w_code == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;
          if ((w_code != EXC_ERET) && (except_cnt_q != CNT_MAX))
            except_cnt_d = except_cnt_q + 16'd1;
        end else begin
          o_stall = w_stall_req;
        end
      end
      ST_FLUSH: begin
        o_flush = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        o_stall = w_stall_req;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset is asynchronous, so combinational outputs are gated too.
    if (i_rst) begin
      o_stall       = STALL_NONE;
      o_except_type = EXC_NONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      new_pc_q     <= 32'h0;
      except_cnt_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      new_pc_q     <= new_pc_d;
      except_cnt_q <= except_cnt_d;
    end
  end

  assign o_new_pc         = new_pc_q;
  assign o_except_cnt     = except_cnt_q;
  assign o_curr_inst_addr = i_mem_inst_addr;
  assign o_delayslot_vld  = i_mem_delayslot;

endmodule

`default_nettype wire
